// File: rtl/obi_burst_master.sv
// OBI initiator that turns a single burst command into a sequence of word
// accesses, with a bounded number of granted-but-unanswered transactions.
module obi_burst_master #(
    parameter int unsigned LEN_W           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [31:0]      cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             cmd_we_i,

    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [31:0]      wr_data_i,

    output logic             rd_valid_o,
    output logic [31:0]      rd_data_o,

    output logic             obi_req_o,
    input  logic             obi_gnt_i,
    output logic [31:0]      obi_addr_o,
    output logic             obi_we_o,
    output logic [3:0]       obi_be_o,
    output logic [31:0]      obi_wdata_o,
    input  logic             obi_rvalid_i,
    input  logic [31:0]      obi_rdata_i,
    input  logic             illegal_i,

    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [2:0]   MAX_OUT = 3'(MAX_OUTSTANDING);
    localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

    state_t          state_q, state_d;
    logic [31:0]     addr_q;
    logic [LEN_W:0]  cnt_q;
    logic            we_q;
    logic [2:0]      out_q, out_d;
    logic            err_q;
    logic            done_q;

    logic            cmd_fire;
    logic            fire;
    logic            rsp;

    assign cmd_ready_o = (state_q == IDLE);
    assign cmd_fire    = cmd_valid_i & cmd_ready_o;

    // Request depends only on registered state and the write source, never on gnt/rvalid.
    assign obi_req_o   = ~rst_i & (state_q == ISSUE) & (out_q < MAX_OUT) & (~we_q | wr_valid_i);
    assign fire        = obi_req_o & obi_gnt_i;
    // Responses arriving with nothing outstanding (e.g. after an abort) are dropped.
    assign rsp         = obi_rvalid_i & (out_q != 3'd0);

    assign obi_addr_o  = addr_q;
    assign obi_we_o    = we_q;
    assign obi_be_o    = 4'hF;
    assign obi_wdata_o = wr_data_i;

    assign wr_ready_o  = fire & we_q;
    assign rd_valid_o  = ~rst_i & rsp & ~we_q;
    assign rd_data_o   = obi_rdata_i;

    assign busy_o      = ~rst_i & (state_q != IDLE);
    assign done_o      = ~rst_i & done_q;
    assign err_o       = ~rst_i & err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid_i) state_d = ISSUE;
            ISSUE:   if (fire && cnt_q == CNT_ONE) state_d = DRAIN;
            DRAIN:   if (rsp && out_q == 3'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d = out_q;
        case ({fire, rsp})
            2'b10:   out_d = out_q + 3'd1;
            2'b01:   out_d = out_q - 3'd1;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            done_q  <= (state_q == DRAIN) && (state_d == IDLE);
            if (cmd_fire) begin
                addr_q <= cmd_addr_i;
                cnt_q  <= {1'b0, cmd_len_i} + CNT_ONE;
                we_q   <= cmd_we_i;
                err_q  <= 1'b0;
            end else if (fire) begin
                addr_q <= addr_q + 32'd4;
                cnt_q  <= cnt_q - CNT_ONE;
                if (illegal_i) err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_burst_master.sv
// Randomised scoreboard bench for obi_burst_master: a responder model drives the
// OBI side, a monitor compares every bus event against queued expectations.
module tb_obi_burst_master;

    localparam int unsigned LW   = 4;
    localparam int unsigned MAXO = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0]   cmd_addr_i;
    logic [LW-1:0] cmd_len_i;
    logic          wr_valid_i, wr_ready_o;
    logic [31:0]   wr_data_i;
    logic          rd_valid_o;
    logic [31:0]   rd_data_o;
    logic          obi_req_o, obi_gnt_i, obi_we_o, obi_rvalid_i, illegal_i;
    logic [31:0]   obi_addr_o, obi_wdata_o, obi_rdata_i;
    logic [3:0]    obi_be_o;
    logic          busy_o, done_o, err_o;

    always #5 clk = ~clk;

    obi_burst_master #(.LEN_W(LW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
        .cmd_len_i(cmd_len_i), .cmd_we_i(cmd_we_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
        .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .illegal_i(illegal_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    // Responder grants and flags illegal accesses in the same cycle as req.
    logic gnt_en, ill_en;
    assign obi_gnt_i = obi_req_o & gnt_en;
    assign illegal_i = obi_req_o & ill_en;

    int unsigned n_tests = 0, n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // Scoreboard queues filled when a command is issued
    logic [31:0] exp_addr[$];
    logic        exp_we[$];
    logic [31:0] exp_wd[$];
    logic [31:0] exp_rd[$];
    int unsigned cmd_words[$];
    logic        cmd_wes[$];
    logic [31:0] wsrc[$];

    // Responder knobs and state
    int unsigned gnt_pct = 100, rsp_dly = 1, gap_pct = 0, ill_pct = 0;
    bit          gnt_once = 0, gnt_block = 0;
    int unsigned cyc = 0;
    int unsigned rsp_due[$];
    logic [31:0] rsp_addr[$];
    logic        s_fire = 0, s_rv = 0, s_wfire = 0;
    logic [31:0] s_addr;

    initial begin
        gnt_en = 0; ill_en = 0; obi_rvalid_i = 0; obi_rdata_i = '0;
        wr_valid_i = 0; wr_data_i = '0;
    end

    always @(negedge clk) begin
        cyc++;
        if (s_wfire && wsrc.size() > 0) void'(wsrc.pop_front());
        if (s_fire) begin
            rsp_due.push_back(cyc - 1 + rsp_dly);
            rsp_addr.push_back(s_addr);
        end
        if (s_rv) begin
            void'(rsp_due.pop_front());
            void'(rsp_addr.pop_front());
        end
        if (!gnt_once) gnt_block = 0;
        else if (s_fire) gnt_block = 1;

        obi_rvalid_i = (rsp_due.size() > 0) && (rsp_due[0] <= cyc);
        obi_rdata_i  = obi_rvalid_i ? mem_f(rsp_addr[0]) : $urandom;
        gnt_en       = !gnt_block && ($urandom_range(99) < gnt_pct);
        ill_en       = $urandom_range(99) < ill_pct;
        // A raised write-valid is held until accepted.
        if (!(wr_valid_i && !s_wfire))
            wr_valid_i = (wsrc.size() > 0) && ($urandom_range(99) >= gap_pct);
        wr_data_i    = wr_valid_i ? wsrc[0] : $urandom;
        #1;
        s_fire  = obi_req_o & obi_gnt_i;
        s_addr  = obi_addr_o;
        s_rv    = obi_rvalid_i;
        s_wfire = wr_valid_i & wr_ready_o;
    end

    // Monitor model state
    int unsigned out_m = 0, issue_left = 0, resp_left = 0;
    bit          cur_we = 0, active_m = 0, done_exp = 0, done_next = 0, err_exp = 0, was_rst = 0;
    bit          exp_req, exp_rv, rsp_m;

    always @(negedge clk) begin
        #2;
        if (rst_i) begin
            check("rst_req",      obi_req_o,  0);
            check("rst_wr_ready", wr_ready_o, 0);
            check("rst_rd_valid", rd_valid_o, 0);
            check("rst_done",     done_o,     0);
            check("rst_err",      err_o,      0);
            check("rst_busy",     busy_o,     0);
            exp_addr.delete(); exp_we.delete(); exp_wd.delete(); exp_rd.delete();
            cmd_words.delete(); cmd_wes.delete();
            out_m = 0; issue_left = 0; resp_left = 0;
            active_m = 0; done_exp = 0; done_next = 0; err_exp = 0;
            was_rst = 1;
        end else begin
            if (was_rst) check("cmd_ready_after_rst", cmd_ready_o, 1);
            was_rst = 0;
            check("busy", busy_o, active_m);
            if (done_o || done_exp) check("done", done_o, done_exp);
            if (err_o || err_exp) check("err", err_o, err_exp);

            exp_req = (issue_left > 0) && (out_m < MAXO) && (!cur_we || wr_valid_i);
            if (exp_req || obi_req_o) check("req", obi_req_o, exp_req);

            if (obi_req_o && obi_gnt_i) begin
                check("outstanding_limit", out_m < MAXO, 1);
                if (exp_addr.size() == 0) check("grant_expected", 0, 1);
                else begin
                    check("addr", obi_addr_o, exp_addr.pop_front());
                    check("we",   obi_we_o,   exp_we[0]);
                    check("be",   obi_be_o,   4'hF);
                    if (exp_we.pop_front()) check("wdata", obi_wdata_o, exp_wd[0]);
                    void'(exp_wd.pop_front());
                end
                check("wr_ready", wr_ready_o, cur_we);
            end else if (wr_ready_o) check("wr_ready_idle", wr_ready_o, 0);

            rsp_m  = obi_rvalid_i && (out_m > 0);
            exp_rv = rsp_m && !cur_we;
            if (exp_rv || rd_valid_o) check("rd_valid", rd_valid_o, exp_rv);
            if (exp_rv) begin
                if (exp_rd.size() == 0) check("rd_expected", 0, 1);
                else check("rd_data", rd_data_o, exp_rd.pop_front());
            end

            done_next = 0;
            if (obi_req_o && obi_gnt_i) begin
                out_m++;
                issue_left--;
                if (illegal_i) err_exp = 1;
            end
            if (rsp_m) begin
                out_m--;
                resp_left--;
                if (resp_left == 0) begin
                    done_next = 1;
                    active_m  = 0;
                end
            end
            if (cmd_valid_i && cmd_ready_o) begin
                if (cmd_words.size() == 0) check("cmd_expected", 0, 1);
                else begin
                    issue_left = cmd_words.pop_front();
                    resp_left  = issue_left;
                    cur_we     = cmd_wes.pop_front();
                    active_m   = 1;
                    err_exp    = 0;
                end
            end
            done_exp = done_next;
        end
    end

    task automatic send(input logic [31:0] a, input int unsigned len, input logic we);
        int unsigned t = 0;
        logic [31:0] d;
        @(negedge clk);
        while (!cmd_ready_o) begin
            if (++t > 3000) begin
                check("cmd_ready_timeout", cmd_ready_o, 1);
                return;
            end
            @(negedge clk);
        end
        cmd_words.push_back(len + 1);
        cmd_wes.push_back(we);
        for (int unsigned i = 0; i <= len; i++) begin
            exp_addr.push_back(a + 32'(4 * i));
            exp_we.push_back(we);
            d = $urandom;
            exp_wd.push_back(d);
            if (we) wsrc.push_back(d);
            else    exp_rd.push_back(mem_f(a + 32'(4 * i)));
        end
        cmd_valid_i = 1; cmd_addr_i = a; cmd_len_i = LW'(len); cmd_we_i = we;
        @(negedge clk);
        cmd_valid_i = 0;
    endtask

    task automatic wait_idle();
        int unsigned t = 0;
        @(negedge clk);
        while (active_m || rsp_due.size() > 0 || !cmd_ready_o) begin
            if (++t > 3000) begin
                check("idle_timeout", active_m, 0);
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int unsigned t;
        rst_i = 1; cmd_valid_i = 0; cmd_addr_i = '0; cmd_len_i = '0; cmd_we_i = 0;
        repeat (2) @(negedge clk);
        rst_i = 0;

        // Directed: write burst, read burst, address wrap, 16-word with slow responses
        send(32'h8000_0000, 3, 1);
        wait_idle();
        send(32'h8000_0100, 1, 0);
        wait_idle();
        send(32'hFFFF_FFFC, 1, 0);
        send(32'hFFFF_FFF8, 2, 1);
        wait_idle();
        rsp_dly = 3;
        send(32'h0000_1000, 15, 0);
        send(32'h0000_2000, 15, 1);
        wait_idle();
        gap_pct = 60; rsp_dly = 1;
        send(32'h0000_3000, 7, 1);
        wait_idle();

        // Randomised bursts, back-to-back, with illegal flags and irregular grants
        for (int unsigned n = 0; n < 40; n++) begin
            gnt_pct = $urandom_range(100, 30);
            rsp_dly = $urandom_range(4, 1);
            gap_pct = $urandom_range(60, 0);
            ill_pct = $urandom_range(15, 0);
            a = {$urandom, 2'b00};
            if (n % 5 == 0) a = 32'hFFFF_FFF0;
            send(a, $urandom_range((1 << LW) - 1, 0), 1'($urandom_range(1, 0)));
            if (n % 8 == 7) wait_idle();
        end
        wait_idle();

        // Abort a read burst with one outstanding; the late response must be dropped
        gnt_pct = 100; ill_pct = 0; gap_pct = 0; rsp_dly = 3; gnt_once = 1;
        send(32'h0000_0100, 3, 0);
        t = 0;
        while (out_m == 0 && t < 100) begin
            @(negedge clk);
            #3;
            t++;
        end
        check("abort_one_outstanding", out_m, 1);
        @(negedge clk);
        rst_i = 1;
        @(negedge clk);
        rst_i = 0;
        gnt_once = 0;
        repeat (6) @(negedge clk);
        wsrc.delete();
        rsp_dly = 1;
        send(32'h0000_0200, 2, 0);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
